queue_calc_driver: RTL and testbench

//   Program sequencer and initiator for the queue calculator interface.

---
 rtl/queue_calc_pkg.sv | 38 +++
 rtl/queue_calc_driver_if.sv | 30 +++
 rtl/queue_calc_prog_mem.sv | 31 +++
 rtl/queue_calc_driver.sv | 187 ++++++++++++++++++
 tb/tb_queue_calc_driver.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/queue_calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : queue_calc_pkg                                                    |
// | Brief  : Shared opcodes, widths and FSM state type for the queue           |
// |          calculator program driver.                                        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package queue_calc_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int QUEUE_SIZE_DEF = 5;
  localparam int PROG_DEPTH_DEF = 16;
  localparam int OP_W           = 3;

  localparam logic [OP_W-1:0] OP_PUSH = 3'd0;
  localparam logic [OP_W-1:0] OP_POP  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd5;
  localparam logic [OP_W-1:0] OP_MOD  = 3'd6;
  localparam logic [OP_W-1:0] OP_HALT = 3'd7;

  // Instruction word is {op, imm}
  function automatic int instr_w(input int data_w);
    return OP_W + data_w;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/queue_calc_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : queue_calc_driver_if                                              |
// | Brief  : Transaction bus between the program driver (master) and the       |
// |          queue calculator (slave).                                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface queue_calc_driver_if
  import queue_calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] calc_in;
  logic [OP_W-1:0]   calc_op;
  logic              calc_apply;
  logic [DATA_W-1:0] calc_tail;
  logic              calc_empty;
  logic              calc_valid;

  modport master (
    output calc_in, calc_op, calc_apply,
    input  calc_tail, calc_empty, calc_valid
  );

  modport slave (
    input  calc_in, calc_op, calc_apply,
    output calc_tail, calc_empty, calc_valid
  );
endinterface
`default_nettype wire

// File: rtl/queue_calc_prog_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : queue_calc_prog_mem                                               |
// | Brief  : Program store, synchronous write / asynchronous read. Contents    |
// |          are deliberately not reset so a program survives rst.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module queue_calc_prog_mem #(
  parameter  int PROG_DEPTH = 16,
  parameter  int WIDTH      = 11,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output      logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [PROG_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/queue_calc_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : queue_calc_driver                                                 |
// | Brief  : Program sequencer for the queue calculator. Issues one {op,imm}   |
// |          per two cycles, checks calc_valid after each, reports the final   |
// |          tail or the PC of the first failing instruction.                  |
// |          Optional: QCD_SHADOW_COUNT_EN adds a shadow occupancy count that  |
// |          stops illegal PUSH/POP/binary ops before they are issued.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module queue_calc_driver
  import queue_calc_pkg::*;
#(
  parameter  int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int QUEUE_SIZE = QUEUE_SIZE_DEF,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   load_we,
  input  wire logic [AW-1:0]          load_addr,
  input  wire logic [OP_W+DATA_W-1:0] load_data,
  input  wire logic                   start,
  queue_calc_driver_if.master         calc,
  output      logic                   busy,
  output      logic                   done,
  output      logic                   error,
  output      logic [DATA_W-1:0]      result,
  output      logic                   result_ok,
  output      logic [AW-1:0]          err_pc
);

  localparam int IW = instr_w(DATA_W);

  if (QUEUE_SIZE < 2) begin : g_bad_queue_size
    $error("QUEUE_SIZE must be at least 2");
  end

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_ok_q, result_ok_d;
  logic [AW-1:0]     err_pc_q, err_pc_d;

  logic [IW-1:0]     instr;
  logic [OP_W-1:0]   cur_op;
  logic [DATA_W-1:0] cur_imm;
  logic              shadow_fault;
  logic              issue_apply;
  logic              mem_we;

  // Program is only writable while no run is in flight
  assign mem_we = load_we && (state_q == ST_IDLE || state_q == ST_DONE);

  queue_calc_prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .WIDTH      (IW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  assign cur_op  = instr[IW-1:DATA_W];
  assign cur_imm = instr[DATA_W-1:0];

`ifdef QCD_SHADOW_COUNT_EN
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Predict calculator over/underflow from the shadow occupancy
  always_comb begin
    shadow_fault = 1'b0;
    case (cur_op)
      OP_PUSH: shadow_fault = (cnt_q == CNT_W'(QUEUE_SIZE));
      OP_POP:  shadow_fault = (cnt_q == '0);
      OP_HALT: shadow_fault = 1'b0;
      default: shadow_fault = (cnt_q < CNT_W'(2));
    endcase
  end

  // Track occupancy of every instruction actually applied
  always_comb begin
    cnt_d = cnt_q;
    if (issue_apply) begin
      if (cur_op == OP_PUSH) cnt_d = cnt_q + CNT_W'(1);
      else                   cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Occupancy register, follows the calculator across runs until rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign shadow_fault = 1'b0;
`endif

  assign issue_apply = (state_q == ST_ISSUE) && (cur_op != OP_HALT) && !shadow_fault;

  // Sequencer next-state and result/error capture
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    result_d    = result_q;
    result_ok_d = result_ok_q;
    err_pc_d    = err_pc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_d        = '0;
          result_d    = '0;
          result_ok_d = 1'b0;
          if (!calc.calc_valid) begin
            state_d  = ST_ERROR;
            err_pc_d = '0;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cur_op == OP_HALT) begin
          state_d     = ST_DONE;
          result_d    = calc.calc_empty ? '0 : calc.calc_tail;
          result_ok_d = !calc.calc_empty;
        end else if (shadow_fault) begin
          state_d  = ST_ERROR;
          err_pc_d = pc_q;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!calc.calc_valid) begin
          state_d  = ST_ERROR;
          err_pc_d = pc_q;
        end else if (pc_q == AW'(PROG_DEPTH - 1)) begin
          // Last slot executed: stop rather than wrap the PC
          state_d     = ST_DONE;
          result_d    = calc.calc_empty ? '0 : calc.calc_tail;
          result_ok_d = !calc.calc_empty;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      result_q    <= '0;
      result_ok_q <= 1'b0;
      err_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      result_q    <= result_d;
      result_ok_q <= result_ok_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign calc.calc_apply = issue_apply;
  assign calc.calc_op    = issue_apply ? cur_op  : '0;
  assign calc.calc_in    = issue_apply ? cur_imm : '0;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign result    = result_q;
  assign result_ok = result_ok_q;
  assign err_pc    = err_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_queue_calc_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_queue_calc_driver                                              |
// | Brief  : Driver paired with a behavioural queue calculator; a program-     |
// |          level predictor gives the expected per-cycle timeline.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_queue_calc_driver;
  import queue_calc_pkg::*;

  localparam int PD = 16;
  localparam int DW = 8;
  localparam int QS = 5;
  localparam int AW = 4;
  localparam int IW = 11;

  typedef logic [DW-1:0] byteq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          busy, done, error, result_ok;
  logic [DW-1:0] result;
  logic [AW-1:0] err_pc;

  queue_calc_driver_if #(.DATA_W(DW)) cif ();

  queue_calc_driver #(
    .PROG_DEPTH (PD),
    .DATA_W     (DW),
    .QUEUE_SIZE (QS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .calc      (cif),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result),
    .result_ok (result_ok),
    .err_pc    (err_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Calculator semantics: binary ops take the two newest entries, result = newest op older
  function automatic void calc_step(input byteq_t qi, input bit vi, input logic [2:0] op,
                                    input logic [DW-1:0] imm, output byteq_t qo, output bit vo);
    logic [DW-1:0] a, b, r;
    qo = qi;
    vo = vi;
    if (!vi) return;
    if (op == OP_PUSH) begin
      if (qo.size() >= QS) vo = 1'b0; else qo.push_back(imm);
    end else if (op == OP_POP) begin
      if (qo.size() == 0) vo = 1'b0; else void'(qo.pop_back());
    end else if (qo.size() < 2) begin
      vo = 1'b0;
    end else begin
      b = qo[qo.size()-1];
      a = qo[qo.size()-2];
      if ((op == OP_DIV || op == OP_MOD) && a == 0) begin
        vo = 1'b0;
      end else begin
        case (op)
          OP_ADD:  r = b + a;
          OP_MUL:  r = b * a;
          OP_SUB:  r = b - a;
          OP_DIV:  r = b / a;
          default: r = b % a;
        endcase
        void'(qo.pop_back());
        void'(qo.pop_back());
        qo.push_back(r);
      end
    end
  endfunction

  // Behavioural calculator on the slave side of the bus
  byteq_t        cq;
  bit            cv = 1'b1;
  logic [DW-1:0] env_tail = '0;
  logic          env_empty = 1'b1;
  logic          env_valid = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cq = {};
      cv = 1'b1;
    end else if (cif.calc_apply) begin
      calc_step(cq, cv, cif.calc_op, cif.calc_in, cq, cv);
    end
    env_tail  <= (cq.size() == 0) ? '0 : cq[cq.size()-1];
    env_empty <= (cq.size() == 0);
    env_valid <= cv;
  end

  assign cif.calc_tail  = env_tail;
  assign cif.calc_empty = env_empty;
  assign cif.calc_valid = env_valid;

  // Program under test and prediction of its run
  logic [IW-1:0] prog [PD];
  int            p_L, p_napp;
  bit            p_ok;
  logic [DW-1:0] p_res;
  bit            p_resok;
  logic [AW-1:0] p_epc;
  logic [IW-1:0] p_app [PD];
  int            done_at, napp_seen;

  function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [DW-1:0] imm);
    return {op, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < PD; i++) prog[i] = ins(OP_HALT, 8'd0);
  endtask

  task automatic predict();
    byteq_t        q;
    bit            v;
    logic [2:0]    op;
    q = cq;
    v = cv;
    p_napp = 0;
    p_ok = 1'b0;
    p_epc = '0;
    p_L = 0;
    if (v) begin
      for (int pc = 0; pc < PD; pc++) begin
        op = prog[pc][IW-1:DW];
        if (op == OP_HALT) begin
          p_L = 2*pc + 1; p_ok = 1'b1; break;
        end
`ifdef QCD_SHADOW_COUNT_EN
        if ((op == OP_PUSH && q.size() == QS) || (op == OP_POP && q.size() == 0) ||
            (op != OP_PUSH && op != OP_POP && q.size() < 2)) begin
          p_L = 2*pc + 1; p_epc = AW'(pc); break;
        end
`endif
        p_app[p_napp] = prog[pc];
        p_napp++;
        calc_step(q, v, op, prog[pc][DW-1:0], q, v);
        if (!v) begin
          p_L = 2*pc + 2; p_epc = AW'(pc); break;
        end
        if (pc == PD - 1) begin
          p_L = 2*pc + 2; p_ok = 1'b1;
        end
      end
    end
    p_resok = p_ok && (q.size() != 0);
    p_res   = p_resok ? q[q.size()-1] : '0;
  endtask

  // One run: optional reset and program load, start, then per-cycle compare
  task automatic run(input string tag, input bit do_reset, input bit do_load);
    bit exp_apply;
    if (do_reset) begin
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
    end
    if (do_load) begin
      for (int a = 1; a < PD; a++) begin
        @(negedge clk);
        load_we = 1'b1; load_addr = AW'(a); load_data = prog[a];
      end
    end
    @(negedge clk);
    predict();
    load_we = do_load; load_addr = '0; load_data = prog[0];
    start = 1'b1;
    @(posedge clk); #1;
    load_we = 1'b0; start = 1'b0;
    done_at = -1;
    napp_seen = 0;
    for (int k = 0; k <= p_L + 4; k++) begin
      @(negedge clk);
      exp_apply = (k % 2 == 0) && (k / 2 < p_napp) && (k < p_L);
      check($sformatf("%s busy k=%0d", tag, k), busy, k < p_L);
      check($sformatf("%s done k=%0d", tag, k), done, p_ok && k >= p_L);
      check($sformatf("%s error k=%0d", tag, k), error, !p_ok && k >= p_L);
      check($sformatf("%s result k=%0d", tag, k), result, (k >= p_L) ? p_res : 8'd0);
      check($sformatf("%s result_ok k=%0d", tag, k), result_ok, (k >= p_L) && p_resok);
      check($sformatf("%s err_pc k=%0d", tag, k), err_pc, (!p_ok && k >= p_L) ? p_epc : 4'd0);
      check($sformatf("%s apply k=%0d", tag, k), cif.calc_apply, exp_apply);
      check($sformatf("%s op/in k=%0d", tag, k), {cif.calc_op, cif.calc_in},
            exp_apply ? p_app[k/2] : 11'd0);
      if (cif.calc_apply) napp_seen++;
      if (done && done_at < 0) done_at = k;
      // A start while in ERROR must be ignored
      start = (!p_ok && k == p_L + 1);
    end
    start = 1'b0;
  endtask

  initial begin
    @(negedge clk); rst = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset result", {result_ok, result}, 0);
    check("reset err_pc", err_pc, 0);
    check("reset apply", {cif.calc_apply, cif.calc_op, cif.calc_in}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // PUSH 3, PUSH 4, ADD, HALT
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd3); prog[1] = ins(OP_PUSH, 8'd4); prog[2] = ins(OP_ADD, 8'd0);
    run("add", 1, 1);
    check("add done_at", done_at, 7);
    check("add result", result, 8'd7);
    check("add result_ok", result_ok, 1);
    check("add error", error, 0);

    // Restart from DONE without reload: calculator now holds [7,7]
    run("restart", 0, 0);
    check("restart result", result, 8'd7);

    // PUSH 10, PUSH 3, SUB
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd10); prog[1] = ins(OP_PUSH, 8'd3); prog[2] = ins(OP_SUB, 8'd0);
    run("sub", 1, 1);
    check("sub result", result, 8'hF9);

    // PUSH 2, PUSH 9, DIV
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd2); prog[1] = ins(OP_PUSH, 8'd9); prog[2] = ins(OP_DIV, 8'd0);
    run("div", 1, 1);
    check("div result", result, 8'd4);

    // Divide by zero
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd0); prog[1] = ins(OP_PUSH, 8'd5); prog[2] = ins(OP_DIV, 8'd0);
    run("div0", 1, 1);
    check("div0 error", error, 1);
    check("div0 err_pc", err_pc, 4'd2);
    check("div0 applies", napp_seen, 3);

    // Six pushes into a five-entry queue
    clear_prog();
    for (int i = 0; i < 6; i++) prog[i] = ins(OP_PUSH, 8'd1);
    run("ovf", 1, 1);
    check("ovf err_pc", err_pc, 4'd5);
`ifdef QCD_SHADOW_COUNT_EN
    check("ovf applies", napp_seen, 5);
`else
    check("ovf applies", napp_seen, 6);
`endif

    // POP on empty queue
    clear_prog();
    prog[0] = ins(OP_POP, 8'd0);
    run("pop0", 1, 1);
    check("pop0 err_pc", err_pc, 4'd0);
    check("pop0 error", error, 1);

    // MUL and POP mix
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd6); prog[1] = ins(OP_PUSH, 8'd7); prog[2] = ins(OP_MUL, 8'd0);
    prog[3] = ins(OP_PUSH, 8'd9); prog[4] = ins(OP_PUSH, 8'd100); prog[5] = ins(OP_MOD, 8'd0);
    prog[6] = ins(OP_POP, 8'd0);
    run("mix", 1, 1);
    check("mix result", result, 8'd42);

    // Full program with no HALT: stops after the last slot
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd1);
    for (int i = 0; i < 7; i++) begin
      prog[1+2*i] = ins(OP_PUSH, 8'd1);
      prog[2+2*i] = ins(OP_ADD, 8'd0);
    end
    prog[15] = ins(OP_PUSH, 8'd2);
    run("full", 1, 1);
    check("full done_at", done_at, 32);
    check("full result", result, 8'd2);
    check("full applies", napp_seen, 16);

    // Reset during CHECK of a 3-instruction run
    clear_prog();
    prog[0] = ins(OP_PUSH, 8'd3); prog[1] = ins(OP_PUSH, 8'd4); prog[2] = ins(OP_ADD, 8'd0);
    run("pre", 1, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst busy before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst state", {busy, done, error, result_ok, result, err_pc}, 0);
    check("midrst apply", {cif.calc_apply, cif.calc_op, cif.calc_in}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst idle", {cif.calc_apply, busy, done, error}, 0);
    end
    run("rerun", 0, 0);
    check("rerun result", result, 8'd7);
    check("rerun done_at", done_at, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
